// File: rtl/fmc_led_pwm_controller.sv
// AXI4-Lite controlled multi-channel LED PWM driver with optional blink gating.
// Optional blink support is compiled in when FMC_LED_BLINK_EN is defined.
`timescale 1ns/1ps
module fmc_led_pwm_controller #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_LEDS           = 8,
    parameter int PWM_BITS           = 8
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]               led
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int WORDS  = 1 << IDX_W;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [IDX_W-1:0] IDX_CTRL  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ON    = IDX_W'(1);
`ifdef FMC_LED_BLINK_EN
    localparam logic [IDX_W-1:0] IDX_BMASK = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_BDIV  = IDX_W'(3);
`endif

    // Handshake: a channel completes on the rising edge where its VALID and READY are
    // both high. AWREADY/WREADY/ARREADY are combinational accept strobes, so they are
    // high only in the single cycle the transfer is taken; B/R VALID then hold until READY.

    logic                            init_done;
    logic                            bvalid_q;
    logic                            rvalid_q;
    logic [DW-1:0]                   rdata_q;
    logic                            wr_en;
    logic                            rd_en;
    logic [IDX_W-1:0]                wr_idx;
    logic [IDX_W-1:0]                rd_idx;
    logic [DW-1:0]                   reg_view [WORDS];
    logic [DW-1:0]                   wr_merged;

    logic                            ctrl_en;
    logic [NUM_LEDS-1:0]             on_mask;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0]             pwm_cnt;
    logic [NUM_LEDS-1:0]             pwm_hit;
    logic [NUM_LEDS-1:0]             blink_term;
    logic [NUM_LEDS-1:0]             on_vec;

    function automatic logic [DW-1:0] apply_strobe(
        input logic [DW-1:0]     old_val,
        input logic [DW-1:0]     new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Blocks acceptance until one full edge has passed since reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) init_done <= 1'b0;
        else                init_done <= 1'b1;
    end

    assign wr_en  = init_done & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_en  = init_done & S_AXI_ARVALID & ~rvalid_q;
    assign wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    assign S_AXI_AWREADY = wr_en;
    assign S_AXI_WREADY  = wr_en;
    assign S_AXI_ARREADY = rd_en;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;

`ifdef FMC_LED_BLINK_EN
    logic [NUM_LEDS-1:0] blink_mask;
    logic [23:0]         blink_div;
    logic [23:0]         presc;
    logic                blink_phase;
`endif

    // Zero-extended view of every word; unmapped words stay 0.
    always_comb begin
        for (int w = 0; w < WORDS; w++) reg_view[w] = '0;
        reg_view[0][0]            = ctrl_en;
        reg_view[1][NUM_LEDS-1:0] = on_mask;
`ifdef FMC_LED_BLINK_EN
        reg_view[2][NUM_LEDS-1:0] = blink_mask;
        reg_view[3][23:0]         = blink_div;
`endif
        for (int i = 0; i < NUM_LEDS; i++) reg_view[4+i][PWM_BITS-1:0] = duty[i];
    end

    assign wr_merged = apply_strobe(reg_view[wr_idx], S_AXI_WDATA, S_AXI_WSTRB);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_en <= 1'b0;
            on_mask <= '0;
            duty    <= '0;
        end else if (wr_en) begin
            if (wr_idx == IDX_CTRL) ctrl_en <= wr_merged[0];
            if (wr_idx == IDX_ON)   on_mask <= wr_merged[NUM_LEDS-1:0];
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_idx == IDX_W'(4 + i)) duty[i] <= wr_merged[PWM_BITS-1:0];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)   bvalid_q <= 1'b0;
        else if (wr_en)       bvalid_q <= 1'b1;
        else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end

    // Read data is captured from the pre-write view, so a same-cycle write is not seen.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= reg_view[rd_idx];
        end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

`ifdef FMC_LED_BLINK_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            blink_mask <= '0;
            blink_div  <= '0;
        end else if (wr_en) begin
            if (wr_idx == IDX_BMASK) blink_mask <= wr_merged[NUM_LEDS-1:0];
            if (wr_idx == IDX_BDIV)  blink_div  <= wr_merged[23:0];
        end
    end

    // A BLINK_DIV write restarts the period with the phase high.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            presc       <= '0;
            blink_phase <= 1'b1;
        end else if (wr_en && wr_idx == IDX_BDIV) begin
            presc       <= '0;
            blink_phase <= 1'b1;
        end else if (presc == blink_div) begin
            presc       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    assign blink_term = ~blink_mask | {NUM_LEDS{blink_phase}};
`else
    assign blink_term = '1;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) pwm_cnt <= '0;
        else                pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Full-scale duty is forced on so the channel never has a one-cycle gap.
    always_comb begin
        pwm_hit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pwm_hit[i] = (duty[i] == '1) | (pwm_cnt < duty[i]);
        end
    end

    assign on_vec = {NUM_LEDS{ctrl_en}} & on_mask & pwm_hit & blink_term;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) led <= '0;
        else                led <= on_vec;
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], wr_merged};

endmodule
